// File: rtl/led_display_ctrl.sv
// led_display_ctrl: shares the 6-LED bank between the decoded value
// and an error source, with a timed new-value flag and blinking alarm.
module led_display_ctrl #(
  parameter int HOLD_TICKS  = 27_000_000,
  parameter int BLINK_TICKS = 6_750_000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bin_valid,
  input  logic [3:0] bin_data,
  output logic       bin_ready,
  input  logic       err_req,
  input  logic [1:0] err_code,
  output logic [5:0] leds,
  output logic       busy
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LD = BW'(BLINK_TICKS - 1);
  localparam logic [5:0] MASK = ACTIVE_LOW ? 6'h3F : 6'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [3:0]      val_q, val_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic [BW-1:0]   blink_cnt, blink_n;
  logic [5:0]      leds_r, led_lg, led_n;
  logic            busy_q;
  logic            xfer;

  // leds_r holds pin polarity; led_lg is the logical view of it
  assign led_lg    = leds_r ^ MASK;
  assign leds      = leds_r;
  assign busy      = busy_q;
  assign bin_ready = !rst && (state != ERR) && !err_req;
  assign xfer      = bin_valid && bin_ready;

  // next-state, counter and LED pattern selection
  always_comb begin
    state_n = state;
    val_n   = val_q;
    hold_n  = hold_cnt;
    blink_n = blink_cnt;
    led_n   = led_lg;
    unique case (state)
      IDLE, SHOW: begin
        if (err_req) begin
          state_n = ERR;
          hold_n  = HOLD_LD;
          blink_n = BLINK_LD;
          led_n   = {4'b1000, err_code};
        end else if (xfer) begin
          state_n = SHOW;
          val_n   = bin_data;
          hold_n  = HOLD_LD;
          led_n   = {2'b01, bin_data};
        end else if (state == IDLE) begin
          led_n = {2'b00, val_q};
        end else if (hold_cnt == '0) begin
          state_n = IDLE;
          led_n   = {2'b00, val_q};
        end else begin
          hold_n = hold_cnt - HW'(1);
          led_n  = {2'b01, val_q};
        end
      end
      ERR: begin
        led_n = {led_lg[5], 3'b000, err_code};
        if (blink_cnt == '0) begin
          led_n[5] = ~led_lg[5];
          blink_n  = BLINK_LD;
        end else begin
          blink_n = blink_cnt - BW'(1);
        end
        if (hold_cnt != '0) begin
          hold_n = hold_cnt - HW'(1);
        end
        if (hold_cnt == '0 && !err_req) begin
          state_n = IDLE;
          led_n   = {2'b00, val_q};
        end
      end
      default: begin
        state_n = IDLE;
        led_n   = 6'b000000;
      end
    endcase
  end

  // state, data, counters and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      val_q     <= '0;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      leds_r    <= MASK;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      val_q     <= val_n;
      hold_cnt  <= hold_n;
      blink_cnt <= blink_n;
      leds_r    <= led_n ^ MASK;
      busy_q    <= (state_n != IDLE);
    end
  end

endmodule

// File: doc/led_display_ctrl.md
# led_display_ctrl

Sequences the 6-LED bank that displays the Gray-decoder result and shares it between two requesters: the decoded 4-bit binary value and an error/status source. New values are accepted over a valid/ready handshake and flagged on LED4 for a fixed hold time. Errors pre-empt the display with a blinking alarm on LED5. The block sits between the Gray-to-binary decoder and the board LED pins, and replaces direct wiring of the binary value to the LEDs.

## Interface
- HOLD_TICKS, default 27_000_000: cycles for the new-value flag and for the minimum error display time (1 s at 27 MHz); legal range ≥ 1.
- BLINK_TICKS, default 6_750_000: cycles per LED5 half-period in error; legal range ≥ 1.
- ACTIVE_LOW, default 0: when 1, all six `leds` bits are inverted at the output register, including during reset.
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- bin_valid  in  1  decoder offers `bin_data`.
- bin_data  in  4  decoded binary value.
- bin_ready  out  1  block accepts `bin_data` this cycle.
- err_req  in  1  level error request.
- err_code  in  2  error code shown while in error.
- leds  out  6  registered LED drive (logical polarity below; inverted if ACTIVE_LOW=1).
- busy  out  1  high when state ≠ IDLE.

## Operation
- Internal state:
  - `val_q[3:0]` holds the last accepted value.
  - FSM states are IDLE, SHOW and ERR.
  - `hold_cnt` and `blink_cnt` are each $clog2-sized for their parameter.
- `bin_ready` is combinational: `!rst && state != ERR && !err_req`.
- A transfer occurs when `bin_valid && bin_ready` at a rising edge.
- Reset values:
  - state = IDLE, `val_q` = 0, both counters = 0.
  - logical `leds` = 6'b000000; `busy` = 0.
- IDLE:
  - `leds` = {2'b00, val_q}.
  - On transfer: `val_q` ← `bin_data`, `leds` ← {2'b01, bin_data}, `hold_cnt` ← HOLD_TICKS−1, go to SHOW.
- SHOW:
  - `leds` = {2'b01, val_q}.
  - A transfer reloads `val_q`, `leds[3:0]` and `hold_cnt` (the flag is retriggered).
  - Otherwise, if `hold_cnt` == 0: go to IDLE with `leds` ← {2'b00, val_q}; else decrement `hold_cnt`.
- Entering ERR from IDLE or SHOW:
  - Trigger: `err_req` sampled high.
  - Actions: state ← ERR, `hold_cnt` ← HOLD_TICKS−1, `blink_cnt` ← BLINK_TICKS−1, `leds` ← {2'b10, 2'b00, err_code}.
  - `err_req` has priority over a simultaneous `bin_valid`. Because `bin_ready` is 0, no transfer happens and `val_q` is unchanged.
  - SHOW is aborted.
- ERR, every cycle:
  - `leds[1:0]` ← `err_code`; `leds[4:2]` = 000.
  - `blink_cnt`: if 0, toggle `leds[5]` and reload BLINK_TICKS−1; else decrement.
  - `hold_cnt` decrements and saturates at 0.
  - Re-asserting `err_req` while in ERR does not reload `hold_cnt`.
- Leaving ERR:
  - Condition: `hold_cnt` == 0 and `err_req` low.
  - Actions: go to IDLE, `leds` ← {2'b00, val_q}. The new-value flag is not restored.
- Reset mid-operation (any state) returns every register to its reset value on that edge. `val_q` is cleared.

## Timing
- Value latency: a transfer at edge k shows `bin_data` on `leds[3:0]` and LED4 = 1 from edge k.
- LED4 stays high exactly HOLD_TICKS cycles after the last transfer, then drops.
- Error latency: `err_req` high at edge k gives LED5 = 1 and `leds[1:0]` = `err_code` from edge k. `bin_ready` falls combinationally in the same cycle `err_req` rises.
- Blink: LED5 stays at each level for BLINK_TICKS cycles; the first toggle occurs BLINK_TICKS cycles after entry.
- Minimum ERR residency is HOLD_TICKS cycles. If `err_req` is low by then, exit happens at edge k+HOLD_TICKS. Otherwise exit is at the first edge `err_req` is sampled low.
- `busy` is a registered decode of state and changes on the same edge as state.
- No combinational path exists from inputs to `leds`.

## Test plan
All scenarios use HOLD_TICKS=4, BLINK_TICKS=2, ACTIVE_LOW=0.
- Reset, then idle 3 cycles -> `leds`=000000, `busy`=0, `bin_ready`=1 after `rst` falls.
- Transfer `bin_data`=4'hA -> `leds`=011010 for 4 cycles, then 001010; `busy` high for exactly 4 cycles.
- Transfer 4'h3, then 4'h5 two cycles later -> `leds`=010101; LED4 stays high 4 cycles after the second transfer (6 total).
- `err_req` and `bin_valid` (4'hF) high together from IDLE with `val_q`=4'hA, `err_code`=2'b10, `err_req` held 1 cycle -> `bin_ready`=0, `leds` follows 100010,100010,000010,000010, then returns to 001010; `val_q` unchanged.
- `err_req` held 10 cycles -> LED5 toggles every 2 cycles throughout; exit on the first edge with `err_req` low; `leds` returns to {00, val_q}.
- Assert `rst` mid-ERR and mid-SHOW -> next cycle `leds`=000000, state IDLE, `val_q`=0. Rerun with ACTIVE_LOW=1 -> `leds`=111111 during reset.
